// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the buffered UART transmit stage.
package uart_tx_fifo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with (AW+1)-bit pointers; push/pop/flush, full/empty/level status.
module sync_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]  r_mem [2**AW];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_rd_ptr_next;
    logic        w_push;
    logic        w_pop;

    assign level   = r_wr_ptr - r_rd_ptr;
    assign full    = (level == (AW+1)'(2**AW));
    assign empty   = (level == '0);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push        = push && !full && !flush;
    assign w_pop         = pop && !empty;
    assign w_rd_ptr_next = w_pop ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;

    // Flush snaps wr_ptr to the post-pop read pointer so a same-cycle pop still completes.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            if (flush)
                r_wr_ptr <= w_rd_ptr_next;
            else if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit buffer: queues bytes and drains them into uart_tx via EN/D/RDY.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned AW      = 4,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic [7:0]    TX_D,
    output logic          TX_EN,
    input  logic          TX_RDY
);

    localparam int unsigned HW = $clog2(HOLDOFF + 1);

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic        w_pop;
    logic [7:0]  w_rd_data;

    sync_fifo #(
        .AW (AW)
    ) u_fifo (
        .CLK       (CLK),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .flush     (flush),
        .rd_data   (w_rd_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty && TX_RDY) begin
                    w_pop        = 1'b1;
                    w_hold_next  = HW'(HOLDOFF);
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // TX_RDY is ignored here: uart_tx has not yet dropped RDY after the pulse.
                w_hold_next = r_hold - HW'(1);
                if (r_hold == HW'(1))
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            TX_EN   <= 1'b0;
            TX_D    <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            TX_EN   <= w_pop;
            if (w_pop)
                TX_D <= w_rd_data;
            if (wr_en && full)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based transmit model.
module tb_uart_tx_fifo;

    localparam int unsigned AW      = 4;
    localparam int unsigned HOLDOFF = 2;
    localparam int unsigned DEPTH   = 16;

    logic          CLK = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic [7:0]    TX_D;
    logic          TX_EN;
    logic          TX_RDY;

    uart_tx_fifo #(
        .AW      (AW),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .flush   (flush),
        .clr_ovf (clr_ovf),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .TX_D    (TX_D),
        .TX_EN   (TX_EN),
        .TX_RDY  (TX_RDY)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a byte queue, a sticky flag, and the cycle of the last pulse.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_en;
    logic [7:0] m_d;
    longint     cyc;
    longint     m_last_pop;
    bit         m_full;
    bit         m_pop;

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_en       = 1'b0;
            m_d        = 8'h00;
            m_last_pop = -100;
        end else begin
            cyc++;
            m_full = (m_q.size() == DEPTH);
            m_pop  = (cyc - m_last_pop > longint'(HOLDOFF)) && (m_q.size() > 0) && (TX_RDY == 1'b1);
            m_en   = m_pop;
            if (m_pop) begin
                m_d        = m_q.pop_front();
                m_last_pop = cyc;
            end
            if (wr_en && m_full)
                m_ovf = 1'b1;
            else if (clr_ovf)
                m_ovf = 1'b0;
            if (flush)
                m_q.delete();
            else if (wr_en && !m_full)
                m_q.push_back(wr_data);
        end
    end

    bit         chk_on = 1'b0;
    logic [7:0] sent[$];
    int         max_level = 0;

    always @(negedge CLK) begin
        if (chk_on) begin
            check("tx_en", int'(TX_EN), int'(m_en));
            check("tx_d",  int'(TX_D),  int'(m_d));
            check("level", int'(level), m_q.size());
            check("full",  int'(full),  int'(m_q.size() == DEPTH));
            check("empty", int'(empty), int'(m_q.size() == 0));
            check("ovf",   int'(ovf),   int'(m_ovf));
            if (TX_EN === 1'b1)
                sent.push_back(TX_D);
            if (int'(level) > max_level)
                max_level = int'(level);
        end
    end

    // Sink behaviour: 0 = constant rdy_const, 1 = slow uart_tx (busy 20 cycles), 2 = random.
    int unsigned sink_mode = 0;
    int unsigned sink_cnt  = 0;
    bit          sink_pend = 1'b0;
    bit          rdy_const = 1'b1;

    task automatic step(input logic we, input logic [7:0] d, input logic fl, input logic co);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
        clr_ovf = co;
        case (sink_mode)
            0: TX_RDY = rdy_const;
            1: begin
                if (TX_EN) begin
                    sink_pend = 1'b1;
                end else if (sink_pend) begin
                    sink_pend = 1'b0;
                    TX_RDY    = 1'b0;
                    sink_cnt  = 20;
                end else if (sink_cnt > 0) begin
                    sink_cnt--;
                    if (sink_cnt == 0)
                        TX_RDY = 1'b1;
                end
            end
            default: TX_RDY = 1'($urandom_range(0, 1));
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    logic [7:0] exp_bytes[$];
    logic [7:0] b;
    int         pushed;
    int         n10;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0; TX_RDY = 1'b1;
        #2 rst = 1'b1;
        #11 rst = 1'b0;
        @(posedge CLK);
        #1;
        chk_on = 1'b1;

        // Reset then idle
        check("rst_empty", int'(empty), 1);
        check("rst_level", int'(level), 0);
        check("rst_ovf",   int'(ovf),   0);
        idle(10);
        check("idle_no_tx", sent.size(), 0);

        // Single byte: level after one edge, pulse after the second
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check("single_level", int'(level), 1);
        check("single_en0",   int'(TX_EN), 0);
        idle(1);
        check("single_en1",   int'(TX_EN), 1);
        check("single_d",     int'(TX_D),  8'h41);
        idle(4);
        check("single_empty", int'(empty), 1);

        // Burst into a slow sink
        sink_mode = 1;
        sent.delete();
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300 && sent.size() < 5; i++)
            idle(1);
        idle(30);
        check("burst_count", sent.size(), 5);
        for (int i = 0; i < 5 && i < sent.size(); i++)
            check("burst_order", int'(sent[i]), 8'h30 + i);

        // Overflow with the sink stalled
        sink_mode = 0;
        rdy_const = 1'b0;
        idle(3);
        for (int i = 0; i < 17; i++)
            step(1'b1, 8'(i), 1'b0, 1'b0);
        check("ovf_full",  int'(full),  1);
        check("ovf_level", int'(level), 16);
        check("ovf_flag",  int'(ovf),   1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr",   int'(ovf),   0);
        sent.delete();
        rdy_const = 1'b1;
        idle(100);
        check("ovf_drain_count", sent.size(), 16);
        if (sent.size() == 16)
            check("ovf_drain_last", int'(sent[15]), 8'h0F);
        n10 = 0;
        foreach (sent[i]) if (sent[i] == 8'h10) n10++;
        check("ovf_dropped_byte", n10, 0);

        // Wrap-around stream with a random sink
        sink_mode = 2;
        sent.delete();
        exp_bytes.delete();
        max_level = 0;
        pushed = 0;
        for (int i = 0; i < 3000 && pushed < 40; i++) begin
            if ($urandom_range(0, 2) != 0 && m_q.size() < DEPTH) begin
                b = 8'($urandom);
                exp_bytes.push_back(b);
                step(1'b1, b, 1'b0, 1'b0);
                pushed++;
            end else begin
                idle(1);
            end
        end
        for (int i = 0; i < 1000 && sent.size() < 40; i++)
            idle(1);
        idle(5);
        check("wrap_count", sent.size(), 40);
        for (int i = 0; i < 40 && i < sent.size(); i++)
            check("wrap_order", int'(sent[i]), int'(exp_bytes[i]));
        check("wrap_max_level", int'(max_level <= 16), 1);

        // Flush with a pop on the same edge
        sink_mode = 0;
        rdy_const = 1'b0;
        idle(5);
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        sent.delete();
        rdy_const = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_en",    int'(TX_EN), 1);
        check("flush_d",     int'(TX_D),  8'hA0);
        check("flush_empty", int'(empty), 1);
        idle(10);
        check("flush_single_pulse", sent.size(), 1);

        // Async reset mid-transfer
        rdy_const = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        rdy_const = 1'b1;
        idle(1);
        check("rst_mid_en_before", int'(TX_EN), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_en",    int'(TX_EN), 0);
        check("rst_mid_d",     int'(TX_D),  0);
        check("rst_mid_level", int'(level), 0);
        check("rst_mid_empty", int'(empty), 1);
        check("rst_mid_full",  int'(full),  0);
        check("rst_mid_ovf",   int'(ovf),   0);
        #3 rst = 1'b0;
        @(posedge CLK);
        #1;
        sent.delete();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        idle(5);
        check("post_rst_count", sent.size(), 1);
        if (sent.size() == 1)
            check("post_rst_byte", int'(sent[0]), 8'h77);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered transmit stage between the CPU memory-mapped UART data register and uart_tx. The CPU write strobe pushes bytes into a small FIFO. The block drains the FIFO into uart_tx using its EN/D/RDY handshake, one byte per RDY-idle window. The CPU can therefore burst several bytes without polling tx ready between each one. The top-level status word reports the block's full/empty/level/overflow outputs.

Parameters:
AW, 4, log2 of FIFO depth (depth = 2^AW = 16 entries)
HOLDOFF, 2, cycles after a TX_EN pulse during which TX_RDY is ignored (covers uart_tx RDY fall latency); must be >= 1

Ports:
CLK  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push strobe from bus decode (one byte per cycle)
wr_data  input  8  byte to push
flush  input  1  synchronous FIFO clear
clr_ovf  input  1  clears sticky overflow flag
full  output  1  count == 2^AW
empty  output  1  count == 0
level  output  AW+1  current entry count
ovf  output  1  sticky: a push was dropped
TX_D  output  8  byte to uart_tx
TX_EN  output  1  one-cycle start pulse to uart_tx
TX_RDY  input  1  uart_tx idle/ready

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, state=IDLE, hold counter=0, TX_EN=0, TX_D=8'h00, ovf=0. Outputs: empty=1, full=0, level=0. Storage contents are don't-care.
- Pointers are AW+1 bits. level = wr_ptr - rd_ptr (modulo 2^(AW+1)). full = level==2^AW. Pointer wrap-around is natural; no special case.
- Push: wr_en && !full (registered full, i.e. value at the start of the cycle) -> mem[wr_ptr[AW-1:0]] <= wr_data, wr_ptr++.
- Push while full: byte dropped, ovf <= 1. This holds even if a pop happens in the same cycle (no write-through).
- ovf: the set condition wins over clr_ovf in the same cycle.
- State IDLE: if !empty && TX_RDY -> TX_D <= mem[rd_ptr], TX_EN <= 1, rd_ptr++, hold <= HOLDOFF, go HOLD. Otherwise TX_EN <= 0.
- State HOLD: TX_EN <= 0 and TX_RDY is ignored. hold decrements each cycle; when hold==1, go IDLE.
- TX_EN is high for exactly one cycle per byte. TX_D is stable from the TX_EN cycle until the next TX_EN.
- Latency: a write at edge N into an empty FIFO with TX_RDY=1 gives level=1 after edge N and TX_EN=1 during the cycle after edge N+1 (2-edge latency).
- Simultaneous push and pop: both take effect; level is unchanged.
- flush: wr_ptr <= rd_ptr (empty next cycle) and takes priority over a same-cycle push.
  - A pop already registered in the same cycle completes: TX_EN and TX_D still go out.
  - State/HOLD sequencing is not interrupted.
- Reset mid-transfer: FIFO contents lost and TX_EN forced to 0 immediately. uart_tx is not reset by this block; the next byte waits for TX_RDY after HOLD-free IDLE.
- Minimum spacing between TX_EN pulses is HOLDOFF+1 cycles. Actual spacing is set by TX_RDY.

Decomposition:
- No shared package needed. AW and HOLDOFF are local parameters; the bus addresses stay in top.
- One natural sub-module: sync_fifo (storage, pointers, full/empty/level, push/pop/flush). uart_tx_fifo adds the IDLE/HOLD drain FSM, ovf, and the uart_tx interface.

Test Plan:
- Reset then idle: rst pulse, TX_RDY=1, no writes -> TX_EN never high; empty=1, level=0, ovf=0.
- Single byte: write 8'h41 with TX_RDY=1 -> level=1 next cycle; TX_EN pulses one cycle, 2 edges after the write, with TX_D=8'h41; empty=1 afterwards.
- Burst with slow sink: write 8'h30..8'h34 in 5 consecutive cycles; TX_RDY model falls 1 cycle after TX_EN and rises 20 cycles later -> five TX_EN pulses in order 30..34, each only after TX_RDY returns high; no duplicates.
- Overflow: TX_RDY=0, write 17 bytes 8'h00..8'h10 -> full=1 after 16, level=16, ovf=1, byte 8'h10 never transmitted. clr_ovf -> ovf=0.
- Wrap-around: 40 bytes streamed with TX_RDY toggling -> all 40 emitted in order; level never exceeds 16.
- Flush and reset mid-operation: 6 bytes queued and one in flight, assert flush -> in-flight TX_EN completes, then empty=1 and no further pulses. Repeat with async rst mid-cycle -> TX_EN drops immediately and all outputs return to reset values.
